// File: rtl/adc_capture_ctrl_if.sv
// Bus bundle between the ADC capture controller and its surroundings:
// arm request, the parallel-ADC handshake and the sample-buffer write port.
interface adc_capture_ctrl_if;
  logic       arm;
  logic       convstb;
  logic       busy;
  logic       csb;
  logic       rdb;
  logic [7:0] db;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done;
  logic       timeout_err;

  // Controller side
  modport master (
    input  arm, busy, db,
    output convstb, csb, rdb, wr_en, wr_addr, wr_data, frame_done, timeout_err
  );

  // ADC / buffer / host side
  modport slave (
    output arm, busy, db,
    input  convstb, csb, rdb, wr_en, wr_addr, wr_data, frame_done, timeout_err
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Parallel ADC capture controller: paces conversions on a fixed sample period,
// runs the convstb/busy/csb/rdb handshake and writes one frame of samples
// into a buffer. Every strobe is a flop output so the ADC never sees glitches.
module adc_capture_ctrl #(
  parameter int unsigned SAMPLE_DIV = 500,
  parameter int unsigned CONV_W     = 4,
  parameter int unsigned RD_W       = 3,
  parameter int unsigned BUSY_TO    = 1023,
  parameter int unsigned DEPTH      = 640
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_capture_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONV    = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_READ    = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  localparam logic [15:0] PER_LAST  = 16'(SAMPLE_DIV - 1);
  localparam logic [15:0] CONV_LAST = 16'(CONV_W - 1);
  localparam logic [15:0] RD_LAST   = 16'(RD_W - 1);
  localparam logic [15:0] TO_LAST   = 16'(BUSY_TO - 1);
  localparam logic [9:0]  ADDR_LAST = 10'(DEPTH - 1);

  state_t      state_q, state_d;
  logic        busy_s1_q, busy_s2_q;
  logic        run_q, run_d;
  logic [15:0] per_q, per_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  addr_q, addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        convstb_q, convstb_d;
  logic        csb_q, csb_d;
  logic        rdb_q, rdb_d;
  logic        wr_en_q, wr_en_d;
  logic        frame_done_q, frame_done_d;
  logic        timeout_q, timeout_d;
  logic        per_tick;

  assign per_tick = (per_q == PER_LAST);

  // Two-flop synchronizer for the asynchronous ADC busy line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_s1_q <= 1'b0;
      busy_s2_q <= 1'b0;
    end else begin
      busy_s1_q <= bus.busy;
      busy_s2_q <= busy_s1_q;
    end
  end

  // Next-state logic: handshake sequencing, period pacing and address/flag updates
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    cnt_d        = cnt_q + 16'd1;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    frame_done_d = 1'b0;
    timeout_d    = timeout_q;

    // Period counter free-runs once armed so conversions stay on the sample grid
    if (run_q) begin
      per_d = per_tick ? 16'd0 : (per_q + 16'd1);
    end else begin
      per_d = per_q;
    end

    // Address advances the clock after its write strobe
    if (wr_en_q) begin
      addr_d = (addr_q == ADDR_LAST) ? 10'd0 : (addr_q + 10'd1);
    end else begin
      addr_d = addr_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (bus.arm) begin
          state_d   = S_CONV;
          addr_d    = 10'd0;
          timeout_d = 1'b0;
          per_d     = 16'd0;
          run_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        if (cnt_q == CONV_LAST) begin
          state_d = S_WAIT_HI;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_CONV;
        end
      end
      S_WAIT_HI: begin
        if (busy_s2_q) begin
          state_d = S_WAIT_LO;
          cnt_d   = 16'd0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_HOLD;
          timeout_d = 1'b1;
          cnt_d     = 16'd0;
        end else begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_LO: begin
        if (!busy_s2_q) begin
          state_d = S_READ;
          cnt_d   = 16'd0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_HOLD;
          timeout_d = 1'b1;
          cnt_d     = 16'd0;
        end else begin
          state_d = S_WAIT_LO;
        end
      end
      S_READ: begin
        if (cnt_q == RD_LAST) begin
          // db is captured while csb/rdb are still low
          wr_data_d = bus.db;
          wr_en_d   = 1'b1;
          cnt_d     = 16'd0;
          if (addr_q == ADDR_LAST) begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
            run_d        = 1'b0;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          state_d = S_READ;
        end
      end
      S_HOLD: begin
        cnt_d = 16'd0;
        if (per_tick) begin
          state_d = S_CONV;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        run_d   = 1'b0;
        cnt_d   = 16'd0;
      end
    endcase

    // Strobes follow the state being entered so they line up with it exactly
    convstb_d = (state_d != S_CONV);
    csb_d     = (state_d != S_READ);
    rdb_d     = (state_d != S_READ);
  end

  // State, counters and registered outputs; reset drops all ADC strobes at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      run_q        <= 1'b0;
      per_q        <= 16'd0;
      cnt_q        <= 16'd0;
      addr_q       <= 10'd0;
      wr_data_q    <= 8'd0;
      convstb_q    <= 1'b1;
      csb_q        <= 1'b1;
      rdb_q        <= 1'b1;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      per_q        <= per_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      convstb_q    <= convstb_d;
      csb_q        <= csb_d;
      rdb_q        <= rdb_d;
      wr_en_q      <= wr_en_d;
      frame_done_q <= frame_done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.convstb     = convstb_q;
  assign bus.csb         = csb_q;
  assign bus.rdb         = rdb_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl (DEPTH=4): basic sample, period spacing,
// full frame and re-arm, ignored arm, busy timeout and reset during a read.
module tb_adc_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm_r = 1'b0;
  logic [7:0] db_r = 8'h00;
  logic       adc_busy = 1'b0;
  logic       adc_en = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int cf[$];
  logic [9:0] wa[$];
  logic [7:0] wd[$];
  logic       wf[$];
  int conv_run = 0, last_conv_w = 0;
  int rd_run = 0, last_rd_w = 0;
  logic conv_prev = 1'b1, csb_prev = 1'b1, to_prev = 1'b0;
  int to_cyc = 0;
  int fd_cnt = 0;
  int strobe_skew = 0;

  adc_capture_ctrl_if bus ();

  assign bus.arm  = arm_r;
  assign bus.db   = db_r;
  assign bus.busy = adc_busy;

  adc_capture_ctrl #(
    .SAMPLE_DIV(500), .CONV_W(4), .RD_W(3), .BUSY_TO(1023), .DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural ADC: busy rises 35 ns after convstb falls, lasts 4.5 us
  always @(negedge bus.convstb) begin
    if (adc_en) begin
      #35;
      adc_busy = 1'b1;
      #4500;
      adc_busy = 1'b0;
    end
  end

  // Observation of strobes and writes, away from the active edge
  always @(negedge clk) begin
    if (bus.convstb === 1'b0) begin
      if (conv_prev) cf.push_back(cyc);
      conv_run++;
    end else begin
      if (!conv_prev) last_conv_w = conv_run;
      conv_run = 0;
    end
    conv_prev = bus.convstb;
    if (bus.csb === 1'b0) begin
      rd_run++;
    end else begin
      if (!csb_prev) last_rd_w = rd_run;
      rd_run = 0;
    end
    csb_prev = bus.csb;
    if (bus.csb !== bus.rdb) strobe_skew++;
    if (bus.wr_en === 1'b1) begin
      wa.push_back(bus.wr_addr);
      wd.push_back(bus.wr_data);
      wf.push_back(bus.frame_done);
    end
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.timeout_err === 1'b1 && !to_prev) to_cyc = cyc;
    to_prev = bus.timeout_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_arm();
    @(negedge clk);
    arm_r = 1'b1;
    @(negedge clk);
    arm_r = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k = 0;
    while (wa.size() < n && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, (wa.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int b;
    int n;
    int k;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_convstb", {31'd0, bus.convstb}, 32'd1);
    check("rst_csb", {31'd0, bus.csb}, 32'd1);
    check("rst_rdb", {31'd0, bus.rdb}, 32'd1);
    check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("rst_wr_addr", {22'd0, bus.wr_addr}, 32'd0);
    check("rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
    check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    check("rst_timeout", {31'd0, bus.timeout_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic sample and a full 4-sample frame
    adc_en = 1'b1;
    db_r = 8'h96;
    pulse_arm();
    wait_writes(1, "basic_wait");
    check("basic_conv_w", last_conv_w, 32'd4);
    check("basic_rd_w", last_rd_w, 32'd3);
    check("basic_addr", {22'd0, wa[0]}, 32'd0);
    check("basic_data", {24'd0, wd[0]}, 32'h96);
    check("basic_fd", {31'd0, wf[0]}, 32'd0);
    db_r = 8'h11;
    wait_writes(2, "f1_w2");
    db_r = 8'h22;
    wait_writes(3, "f1_w3");
    db_r = 8'h33;
    wait_writes(4, "f1_w4");
    check("f1_addr1", {22'd0, wa[1]}, 32'd1);
    check("f1_addr2", {22'd0, wa[2]}, 32'd2);
    check("f1_addr3", {22'd0, wa[3]}, 32'd3);
    check("f1_data1", {24'd0, wd[1]}, 32'h11);
    check("f1_data3", {24'd0, wd[3]}, 32'h33);
    check("f1_fd_mid", {31'd0, wf[2]}, 32'd0);
    check("f1_fd_last", {31'd0, wf[3]}, 32'd1);
    check("f1_fd_cnt", fd_cnt, 32'd1);
    check("f1_period", cf[1] - cf[0], 32'd500);
    n = cf.size();
    repeat (700) @(negedge clk);
    #1;
    check("f1_idle_noconv", cf.size(), n);
    check("f1_addr_wrap", {22'd0, bus.wr_addr}, 32'd0);

    // Second frame: restart at 0, period spacing, arm ignored in WAIT_LO
    b = cf.size();
    db_r = 8'h90;
    pulse_arm();
    wait_writes(5, "f2_w1");
    db_r = 8'h96;
    wait_writes(6, "f2_w2");
    db_r = 8'h3C;
    k = 0;
    while (!adc_busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("f2_busy_seen", {31'd0, adc_busy}, 32'd1);
    repeat (100) @(negedge clk);
    pulse_arm();
    wait_writes(7, "f2_w3");
    db_r = 8'hA5;
    wait_writes(8, "f2_w4");
    check("f2_addr0", {22'd0, wa[4]}, 32'd0);
    check("f2_addr1", {22'd0, wa[5]}, 32'd1);
    check("f2_addr2", {22'd0, wa[6]}, 32'd2);
    check("f2_addr3", {22'd0, wa[7]}, 32'd3);
    check("f2_data0", {24'd0, wd[4]}, 32'h90);
    check("f2_data1", {24'd0, wd[5]}, 32'h96);
    check("f2_data2", {24'd0, wd[6]}, 32'h3C);
    check("f2_data3", {24'd0, wd[7]}, 32'hA5);
    check("f2_period01", cf[b + 1] - cf[b], 32'd500);
    check("f2_period12", cf[b + 2] - cf[b + 1], 32'd500);
    check("f2_period23", cf[b + 3] - cf[b + 2], 32'd500);
    check("f2_fd_last", {31'd0, wf[7]}, 32'd1);
    check("f2_fd_cnt", fd_cnt, 32'd2);
    check("strobe_skew", strobe_skew, 32'd0);
    repeat (50) @(negedge clk);

    // Busy timeout: busy held low
    adc_en = 1'b0;
    b = cf.size();
    n = wa.size();
    pulse_arm();
    k = 0;
    while (bus.timeout_err !== 1'b1 && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    check("to_flag", {31'd0, bus.timeout_err}, 32'd1);
    k = 0;
    while (cf.size() < b + 2 && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    check("to_delay", to_cyc - cf[b], 32'd1027);
    check("to_next_conv", cf[b + 1] - cf[b], 32'd1500);
    check("to_no_write", wa.size(), n);
    check("to_addr", {22'd0, bus.wr_addr}, 32'd0);

    // Reset in the middle of a read
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rr_to_cleared", {31'd0, bus.timeout_err}, 32'd0);
    adc_en = 1'b1;
    db_r = 8'h55;
    n = wa.size();
    pulse_arm();
    k = 0;
    while (bus.rdb !== 1'b0 && k < 1000) begin
      @(negedge clk); #1;
      k++;
    end
    check("rr_rdb_low", {31'd0, bus.rdb}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rr_convstb", {31'd0, bus.convstb}, 32'd1);
    check("rr_csb", {31'd0, bus.csb}, 32'd1);
    check("rr_rdb", {31'd0, bus.rdb}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    #1;
    check("rr_no_write", wa.size(), n);
    check("rr_addr", {22'd0, bus.wr_addr}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 500, meaning clocks per sample period (200 kSps at 100 MHz); legal range 32..65535.
REQ-002 The block SHALL have parameter CONV_W, default 4, meaning convstb low-pulse width in clocks.
REQ-003 The block SHALL have parameter RD_W, default 3, meaning csb/rdb low width in clocks.
REQ-004 The block SHALL have parameter BUSY_TO, default 1023, meaning clocks allowed per busy phase before timeout.
REQ-005 The block SHALL have parameter DEPTH, default 640, meaning samples per frame (one per VGA column).
REQ-006 The block SHALL have port clk, input, 1, 100 MHz system clock; all logic SHALL run on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-008 The block SHALL have port arm, input, 1, one-cycle pulse that starts capture of one frame.
REQ-009 The block SHALL have port convstb, output, 1, ADC conversion start, active-low.
REQ-010 The block SHALL have port busy, input, 1, ADC converting, active-high, asynchronous to clk.
REQ-011 The block SHALL have port csb, output, 1, ADC chip select, active-low.
REQ-012 The block SHALL have port rdb, output, 1, ADC read strobe, active-low.
REQ-013 The block SHALL have port db, input, 8, ADC parallel data.
REQ-014 The block SHALL have port wr_en, output, 1, one-cycle sample-buffer write strobe.
REQ-015 The block SHALL have port wr_addr, output, 10, sample-buffer write address.
REQ-016 The block SHALL have port wr_data, output, 8, sample value to write.
REQ-017 The block SHALL have port frame_done, output, 1, one-cycle pulse after the last sample of a frame is written.
REQ-018 The block SHALL have port timeout_err, output, 1, sticky busy-timeout flag, cleared by arm or rst.

Function
REQ-019 busy SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value.
REQ-020 The FSM SHALL have states IDLE, CONV, WAIT_HI, WAIT_LO, READ, HOLD.
REQ-021 IDLE: on arm, the FSM SHALL clear the address counter and timeout_err, restart the period counter at 0, and go to CONV on the next clock.
REQ-022 CONV: convstb SHALL be low for exactly CONV_W clocks, then the FSM SHALL go to WAIT_HI.
REQ-023 WAIT_HI: the FSM SHALL go to WAIT_LO on synchronized busy=1.
REQ-024 WAIT_LO: the FSM SHALL go to READ on synchronized busy=0.
REQ-025 Timeout: if WAIT_HI or WAIT_LO lasts BUSY_TO clocks, the FSM SHALL set timeout_err, write no sample, not advance wr_addr, and go to HOLD.
REQ-026 READ: csb and rdb SHALL be low together for exactly RD_W clocks; db SHALL be registered on the last low clock.
REQ-027 In the clock after READ, wr_en SHALL pulse for 1 clock with wr_data equal to the registered db and wr_addr equal to the current address, then the address SHALL increment.
REQ-028 HOLD: the FSM SHALL wait for the period counter to reach SAMPLE_DIV-1, then go to CONV; convstb falling edges SHALL be exactly SAMPLE_DIV clocks apart.
REQ-029 The period counter SHALL run free from arm, independent of FSM state; if a conversion overruns the period, the next CONV SHALL start at the following period boundary (one sample is dropped, with no back-to-back CONV).
REQ-030 After the write to address DEPTH-1, frame_done SHALL pulse in the same cycle as that wr_en, the address SHALL wrap to 0, and the FSM SHALL return to IDLE.
REQ-031 arm received outside IDLE SHALL be ignored.
REQ-032 Outputs SHALL be glitch-free: convstb, csb, rdb, wr_en, frame_done, wr_addr and wr_data SHALL all be registered outputs.

Reset
REQ-033 While rst=1, the block SHALL force state IDLE, convstb=1, csb=1, rdb=1, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, timeout_err=0, and all counters and synchronizer flops to 0.
REQ-034 rst asserted mid-conversion or mid-read SHALL deassert all ADC strobes immediately (asynchronously) and discard the partial sample.

Verification
REQ-035 Basic sample: arm; busy rises 35 ns after convstb falls and falls 4.5 us later; db=8'h96 -> convstb low 4 clks, csb=rdb=0 for 3 clks, wr_en with wr_addr=0, wr_data=8'h96.
REQ-036 Period: two consecutive samples -> convstb falling edges exactly 500 clks apart, wr_addr 0 then 1, with db=8'h90 then 8'h96 written in order.
REQ-037 Frame: DEPTH=4 with a behavioural ADC model -> 4 writes to addresses 0..3, frame_done coincident with the addr-3 write, then IDLE; a second arm restarts at addr 0.
REQ-038 Timeout: busy held 0 -> timeout_err=1 after 1023 clks in WAIT_HI, no wr_en, next CONV on the following period boundary, address unchanged.
REQ-039 Reset mid-READ: rst asserted while rdb=0 -> convstb, csb and rdb go high without waiting for a clock edge, no wr_en, wr_addr=0 after release.
REQ-040 Arm ignore: arm pulsed during WAIT_LO -> no effect on the address or timing.
